// File: rtl/io_timer_pkg.sv
// Shared IOMEM timer definitions: register offsets, CTRL bit positions and the
// IOMEM window constants that the memory controller decode also relies on.
package io_timer_pkg;
  localparam logic [7:0]  IOMEM_BASE = 8'h08;
  localparam int unsigned IOMEM_SIZE = 8;
  localparam int unsigned IOMEM_AW   = $clog2(IOMEM_SIZE);

  typedef enum logic [2:0] {
    OFS_CTRL   = 3'd0,
    OFS_CNT_LO = 3'd1,
    OFS_CNT_HI = 3'd2,
    OFS_CMP_LO = 3'd3,
    OFS_CMP_HI = 3'd4,
    OFS_STATUS = 3'd5,
    OFS_RSVD6  = 3'd6,
    OFS_RSVD7  = 3'd7
  } reg_ofs_e;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_AUTO   = 1;
  localparam int unsigned CTRL_IE     = 2;
  localparam int unsigned CTRL_PS_LSB = 4;

  function automatic logic in_window(input logic [7:0] addr, input logic [7:0] base);
    return addr[7:IOMEM_AW] == base[7:IOMEM_AW];
  endfunction
endpackage

// File: rtl/io_timer_prescaler.sv
// Power-of-two prescaler: emits a one-cycle tick every 2^ps running cycles.
module io_prescaler #(
  parameter int unsigned PS_BITS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               clr,
  input  logic [PS_BITS-1:0] ps,
  output logic               tick
);
  localparam int unsigned PRE_W = (1 << PS_BITS) - 1;

  logic [PRE_W-1:0] pre_q, pre_d, mask;

  always_comb begin
    mask  = ~({PRE_W{1'b1}} << ps);
    tick  = run && (pre_q == mask);
    pre_d = pre_q;
    if (clr || tick) begin
      pre_d = '0;
    end else if (run) begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
endmodule

// File: rtl/io_timer.sv
// Memory-mapped 16-bit timer/counter in the IOMEM window, with compare-match
// interrupt and the same read/write timing as the core register file.
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = IOMEM_BASE,
  parameter int unsigned PS_BITS   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic [7:0] writeaddr,
  input  logic [7:0] writedata,
  input  logic       write_en,
  input  logic [7:0] readaddr,
  output logic [7:0] readdata,
  output logic       sel,
  output logic       irq
);
  logic               en_q, en_d, auto_q, auto_d, ie_q, ie_d;
  logic [PS_BITS-1:0] ps_q, ps_d;
  logic [15:0]        count_q, count_d, cmp_q, cmp_d;
  logic               match_q, match_d;
  logic [7:0]         hi_shadow_q, hi_shadow_d, hi_wbuf_q, hi_wbuf_d;
  logic [7:0]         raddr_q, raddr_d, waddr_q, waddr_d, wdata_q, wdata_d;
  logic               we_q, we_d;

  logic       wr_hit, ctrl_wr, run, tick, bypass;
  reg_ofs_e   wofs, rofs;
  logic [7:0] ctrl_rd, reg_rd;

  assign wr_hit  = write_en && in_window(writeaddr, BASE_ADDR);
  assign wofs    = reg_ofs_e'(writeaddr[2:0]);
  assign ctrl_wr = wr_hit && (wofs == OFS_CTRL);
  // A CTRL write that clears en must already block the tick on its own edge.
  assign run     = en_q && !pause && !(ctrl_wr && !writedata[CTRL_EN]);
  assign irq     = ie_q && match_q;

  io_prescaler #(.PS_BITS(PS_BITS)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .clr   (ctrl_wr),
    .ps    (ps_q),
    .tick  (tick)
  );

  always_comb begin
    en_d        = en_q;
    auto_d      = auto_q;
    ie_d        = ie_q;
    ps_d        = ps_q;
    count_d     = count_q;
    cmp_d       = cmp_q;
    match_d     = match_q;
    hi_wbuf_d   = hi_wbuf_q;
    hi_shadow_d = hi_shadow_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    if (wr_hit) begin
      case (wofs)
        OFS_CTRL: begin
          en_d   = writedata[CTRL_EN];
          auto_d = writedata[CTRL_AUTO];
          ie_d   = writedata[CTRL_IE];
          ps_d   = writedata[CTRL_PS_LSB +: PS_BITS];
        end
        OFS_CNT_HI: hi_wbuf_d = writedata;
        OFS_CMP_LO: cmp_d[7:0] = writedata;
        OFS_CMP_HI: cmp_d[15:8] = writedata;
        OFS_STATUS: if (writedata[0]) match_d = 1'b0;
        default: ;
      endcase
    end
    // Match set is applied after W1C so a coincident set wins.
    if (wr_hit && (wofs == OFS_CNT_LO)) begin
      count_d = {hi_wbuf_q, writedata};
    end else if (tick) begin
      count_d = count_q + 16'd1;
      if (count_q == cmp_q) begin
        match_d = 1'b1;
        if (auto_q) count_d = '0;
      end
    end
    if (!pause) begin
      raddr_d = readaddr;
      waddr_d = writeaddr;
      wdata_d = writedata;
      we_d    = write_en;
      if (in_window(readaddr, BASE_ADDR) && (reg_ofs_e'(readaddr[2:0]) == OFS_CNT_LO)) begin
        hi_shadow_d = count_d[15:8];
      end
    end
  end

  always_comb begin
    rofs    = reg_ofs_e'(raddr_q[2:0]);
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN]   = en_q;
    ctrl_rd[CTRL_AUTO] = auto_q;
    ctrl_rd[CTRL_IE]   = ie_q;
    ctrl_rd[CTRL_PS_LSB +: PS_BITS] = ps_q;
    case (rofs)
      OFS_CTRL:   reg_rd = ctrl_rd;
      OFS_CNT_LO: reg_rd = count_q[7:0];
      OFS_CNT_HI: reg_rd = hi_shadow_q;
      OFS_CMP_LO: reg_rd = cmp_q[7:0];
      OFS_CMP_HI: reg_rd = cmp_q[15:8];
      OFS_STATUS: reg_rd = {7'd0, match_q};
      default:    reg_rd = 8'h00;
    endcase
    // STATUS and CNT_HI never bypass: their read value differs from what was written.
    bypass   = we_q && (waddr_q == raddr_q) && (rofs != OFS_STATUS) && (rofs != OFS_CNT_HI);
    sel      = in_window(raddr_q, BASE_ADDR);
    readdata = !sel ? 8'h00 : (bypass ? wdata_q : reg_rd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q        <= 1'b0;
      auto_q      <= 1'b0;
      ie_q        <= 1'b0;
      ps_q        <= '0;
      count_q     <= '0;
      cmp_q       <= 16'hFFFF;
      match_q     <= 1'b0;
      hi_wbuf_q   <= '0;
      hi_shadow_q <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
    end else begin
      en_q        <= en_d;
      auto_q      <= auto_d;
      ie_q        <= ie_d;
      ps_q        <= ps_d;
      count_q     <= count_d;
      cmp_q       <= cmp_d;
      match_q     <= match_d;
      hi_wbuf_q   <= hi_wbuf_d;
      hi_shadow_q <= hi_shadow_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
    end
  end
endmodule

// File: tb/tb_io_timer.sv
// Scoreboard bench for io_timer: stimulus pushes hand-computed read results,
// a monitor pops and compares them one cycle after each read is issued.
module tb_io_timer;
  logic       clk;
  logic       reset;
  logic       pause;
  logic [7:0] writeaddr;
  logic [7:0] writedata;
  logic       write_en;
  logic [7:0] readaddr;
  logic [7:0] readdata;
  logic       sel;
  logic       irq;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       sel;
    logic       irq;
  } exp_t;

  exp_t sb_q[$];
  logic rd_issue;
  int   total;
  int   bad;

  io_timer dut (
    .clk       (clk),
    .reset     (reset),
    .pause     (pause),
    .writeaddr (writeaddr),
    .writedata (writedata),
    .write_en  (write_en),
    .readaddr  (readaddr),
    .readdata  (readdata),
    .sel       (sel),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%02h required=%02h", nm, act, exp);
    end
  endtask

  // Drives one cycle of inputs; when chk is set the expected result is queued.
  task automatic applyStimulus(input logic we, input logic [7:0] wa, input logic [7:0] wd,
                               input logic [7:0] ra, input logic chk, input logic [7:0] ed,
                               input logic es, input logic ei, input string nm);
    exp_t e;
    write_en  = we;
    writeaddr = wa;
    writedata = wd;
    readaddr  = ra;
    rd_issue  = chk;
    if (chk) begin
      e.name = nm;
      e.data = ed;
      e.sel  = es;
      e.irq  = ei;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic winSel(input logic [7:0] ra);
    return (ra >= 8'h08) && (ra <= 8'h0F);
  endfunction

  task automatic rd(input logic [7:0] ra, input logic [7:0] ed, input logic ei, input string nm);
    applyStimulus(1'b0, 8'h00, 8'h00, ra, 1'b1, ed, winSel(ra), ei, nm);
  endtask

  task automatic wr(input logic [7:0] wa, input logic [7:0] wd);
    applyStimulus(1'b1, wa, wd, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "");
  endtask

  task automatic wrd(input logic [7:0] wa, input logic [7:0] wd, input logic [7:0] ra,
                     input logic [7:0] ed, input logic ei, input string nm);
    applyStimulus(1'b1, wa, wd, ra, 1'b1, ed, winSel(ra), ei, nm);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "");
  endtask

  // Monitor: a read issued before an edge is checked mid-cycle after that edge.
  initial begin : monitor
    exp_t e;
    logic issued;
    forever begin
      @(posedge clk);
      issued = rd_issue;
      @(negedge clk);
      if (issued) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL sb_underflow: actual=empty required=entry");
        end else begin
          e = sb_q.pop_front();
          checkOutput({e.name, "_data"}, readdata, e.data);
          checkOutput({e.name, "_sel"}, {7'd0, sel}, {7'd0, e.sel});
          checkOutput({e.name, "_irq"}, {7'd0, irq}, {7'd0, e.irq});
        end
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    rd_issue = 1'b0;
    reset = 1'b1;
    pause = 1'b0;
    write_en = 1'b0;
    writeaddr = 8'h00;
    writedata = 8'h00;
    readaddr = 8'h00;

    // Reset: a read during reset must not be captured
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h08, 1'b1, 8'h00, 1'b0, 1'b0, "rst_read");
    idle();
    reset = 1'b0;
    rd(8'h08, 8'h00, 1'b0, "t1_ctrl");
    rd(8'h09, 8'h00, 1'b0, "t1_cntlo");
    rd(8'h0A, 8'h00, 1'b0, "t1_cnthi");
    rd(8'h0B, 8'hFF, 1'b0, "t1_cmplo");
    rd(8'h0C, 8'hFF, 1'b0, "t1_cmphi");
    rd(8'h0D, 8'h00, 1'b0, "t1_status");
    rd(8'h0E, 8'h00, 1'b0, "t1_rsvd6");
    rd(8'h0F, 8'h00, 1'b0, "t1_rsvd7");

    // Autoreload compare at 3, ps0, irq enabled
    wr(8'h0B, 8'h03);
    wr(8'h0C, 8'h00);
    wrd(8'h08, 8'h07, 8'h09, 8'h00, 1'b0, "t2_cnt0");
    rd(8'h09, 8'h01, 1'b0, "t2_cnt1");
    rd(8'h09, 8'h02, 1'b0, "t2_cnt2");
    rd(8'h09, 8'h03, 1'b0, "t2_cnt3");
    rd(8'h09, 8'h00, 1'b1, "t2_wrap");
    rd(8'h0D, 8'h01, 1'b1, "t2_status");
    wrd(8'h0D, 8'h01, 8'h0D, 8'h00, 1'b0, "t2_w1c");
    rd(8'h09, 8'h03, 1'b0, "t2_cnt3b");
    wrd(8'h08, 8'h00, 8'h09, 8'h03, 1'b0, "t2_stop");
    rd(8'h0D, 8'h00, 1'b0, "t2_nomatch");

    // ps=2, no autoreload, wrap FFFF -> 0000 with match
    wrd(8'h0A, 8'hFF, 8'h0A, 8'h00, 1'b0, "t3_hi_nobyp");
    wrd(8'h09, 8'hFE, 8'h09, 8'hFE, 1'b0, "t3_lo_byp");
    wrd(8'h0B, 8'hFF, 8'h0A, 8'hFF, 1'b0, "t3_shadow");
    wrd(8'h0C, 8'hFF, 8'h0C, 8'hFF, 1'b0, "t3_cmphi");
    wrd(8'h08, 8'h21, 8'h08, 8'h21, 1'b0, "t3_ctrl");
    for (int i = 0; i < 3; i++) rd(8'h09, 8'hFE, 1'b0, "t3_wait");
    rd(8'h09, 8'hFF, 1'b0, "t3_tick1");
    for (int i = 0; i < 3; i++) rd(8'h09, 8'hFF, 1'b0, "t3_hold");
    rd(8'h09, 8'h00, 1'b0, "t3_wrap");
    rd(8'h0D, 8'h01, 1'b0, "t3_match");
    wrd(8'h08, 8'h00, 8'h0A, 8'h00, 1'b0, "t3_shadow0");
    wr(8'h0D, 8'h01);

    // Coherent 16-bit read across a low-byte carry
    wr(8'h0A, 8'h12);
    wr(8'h09, 8'hFC);
    wr(8'h08, 8'h01);
    idle();
    idle();
    rd(8'h09, 8'hFF, 1'b0, "t4_lo");
    rd(8'h0A, 8'h12, 1'b0, "t4_hi");
    rd(8'h09, 8'h01, 1'b0, "t4_lo2");
    rd(8'h0A, 8'h13, 1'b0, "t4_hi2");
    wr(8'h08, 8'h00);

    // Counter load on a tick edge, then read bypass
    wr(8'h08, 8'h01);
    wr(8'h0A, 8'hAB);
    wrd(8'h09, 8'hCD, 8'h09, 8'hCD, 1'b0, "t5_lo_byp");
    rd(8'h09, 8'hCE, 1'b0, "t5_next");
    rd(8'h0A, 8'hAB, 1'b0, "t5_hi");
    wr(8'h08, 8'h00);
    wrd(8'h0B, 8'hD1, 8'h0B, 8'hD1, 1'b0, "t5_cmplo_byp");
    wrd(8'h0C, 8'hAB, 8'h0C, 8'hAB, 1'b0, "t5_cmphi");
    wrd(8'h0E, 8'h77, 8'h0E, 8'h77, 1'b0, "t5_rsvd_byp");
    rd(8'h0E, 8'h00, 1'b0, "t5_rsvd");
    wrd(8'h08, 8'h88, 8'h08, 8'h88, 1'b0, "t5_ctrl_byp");
    rd(8'h08, 8'h00, 1'b0, "t5_ctrl_mask");

    // Pause freezes counting and read capture; W1C still lands
    wr(8'h08, 8'h05);
    rd(8'h09, 8'hD0, 1'b0, "t6_run0");
    rd(8'h09, 8'hD1, 1'b0, "t6_run1");
    rd(8'h09, 8'hD2, 1'b1, "t6_match");
    pause = 1'b1;
    rd(8'h0B, 8'hD2, 1'b1, "t6_p1");
    rd(8'h0B, 8'hD2, 1'b1, "t6_p2");
    wrd(8'h0D, 8'h01, 8'h0B, 8'hD2, 1'b0, "t6_p3_w1c");
    rd(8'h0B, 8'hD2, 1'b0, "t6_p4");
    rd(8'h0B, 8'hD2, 1'b0, "t6_p5");
    pause = 1'b0;
    rd(8'h09, 8'hD3, 1'b0, "t6_resume");
    rd(8'h0D, 8'h00, 1'b0, "t6_status");
    rd(8'h20, 8'h00, 1'b0, "t6_out20");
    rd(8'h07, 8'h00, 1'b0, "t6_out07");
    rd(8'h10, 8'h00, 1'b0, "t6_out10");
    wr(8'h08, 8'h00);

    // Reset again from a dirty state
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h0C, 1'b1, 8'h00, 1'b0, 1'b0, "rst2_read");
    reset = 1'b0;
    rd(8'h0C, 8'hFF, 1'b0, "rst2_cmp");
    rd(8'h09, 8'h00, 1'b0, "rst2_cnt");
    rd(8'h08, 8'h00, 1'b0, "rst2_ctrl");
    idle();
    idle();

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL sb_drain: actual=%0d required=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
